// File: rtl/inst_decode_stage.sv
// inst_decode_stage: registered RV32 decode stage with valid/ready flow
// control. Splits the instruction into its fields, builds the sign-extended
// immediate and format tag, nulls unused register indices and flags illegal
// encodings. A two-entry (main + skid) buffer lets the upstream and downstream
// sides stall independently while keeping in_ready purely registered.
module inst_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic            out_func7b,
    output logic            out_mulbit,
    output logic [4:0]      out_func5,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam logic [2:0] F_R = 3'd0;
    localparam logic [2:0] F_I = 3'd1;
    localparam logic [2:0] F_S = 3'd2;
    localparam logic [2:0] F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4;
    localparam logic [2:0] F_J = 3'd5;

    typedef struct packed {
        logic [4:0]      opcode;
        logic [2:0]      func3;
        logic            func7b;
        logic            mulbit;
        logic [4:0]      func5;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } entry_t;

    logic [1:0] state_q, state_d;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    entry_t     dec;
    logic       accept, fire;
    logic       legal;
    logic [2:0] fmt;
    logic [31:0] imm32;

    // Combinational field decode of the incoming instruction
    always_comb begin
        dec         = '0;
        legal       = 1'b1;
        fmt         = F_R;
        imm32       = '0;
        dec.opcode  = in_inst[6:2];
        dec.func3   = in_inst[14:12];
        dec.func7b  = in_inst[30];
        dec.mulbit  = in_inst[25] & (in_inst[6:2] == 5'b01100);
        dec.func5   = in_inst[31:27];
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.rd      = in_inst[11:7];
        dec.pc      = in_pc;
        case (in_inst[6:2])
            5'b01100:                               fmt = F_R;
            5'b00100, 5'b00000, 5'b11001, 5'b11100: fmt = F_I;
            5'b01000:                               fmt = F_S;
            5'b11000:                               fmt = F_B;
            5'b01101, 5'b00101:                     fmt = F_U;
            5'b11011:                               fmt = F_J;
            default:                                legal = 1'b0;
        endcase
        if (in_inst[1:0] != 2'b11) legal = 1'b0;
        case (fmt)
            F_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            F_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            F_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                          in_inst[30:25], in_inst[11:8], 1'b0};
            F_U: imm32 = {in_inst[31:12], 12'b0};
            F_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                          in_inst[20], in_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        if (!legal) begin
            // illegal entries keep raw indices so a trap handler can see them
            dec.illegal = 1'b1;
            dec.fmt     = F_R;
            dec.imm     = '0;
        end else begin
            dec.fmt = fmt;
            dec.imm = XLEN'($signed(imm32));
            if (fmt == F_S || fmt == F_B) dec.rd = '0;
            if (fmt == F_I || fmt == F_U || fmt == F_J) dec.rs2 = '0;
            if (fmt == F_U || fmt == F_J) dec.rs1 = '0;
        end
    end

    // Buffer state and entry registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state and buffer moves; flush overrides everything
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: if (accept) begin
                main_d  = dec;
                state_d = S_ONE;
            end
            S_ONE: begin
                if (fire && accept) begin
                    main_d = dec;
                end else if (fire) begin
                    state_d = S_EMPTY;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = S_TWO;
                end
            end
            S_TWO: if (fire) begin
                main_d  = skid_q;
                state_d = S_ONE;
            end
            default: state_d = S_EMPTY;
        endcase
        if (flush) state_d = S_EMPTY;
    end

    // Handshake outputs derived only from registered state
    always_comb begin
        in_ready  = (state_q != S_TWO);
        out_valid = (state_q == S_ONE) || (state_q == S_TWO);
        accept    = in_valid & in_ready;
        fire      = out_valid & out_ready;
    end

    assign out_opcode  = main_q.opcode;
    assign out_func3   = main_q.func3;
    assign out_func7b  = main_q.func7b;
    assign out_mulbit  = main_q.mulbit;
    assign out_func5   = main_q.func5;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_pc      = main_q.pc;

endmodule
